timer_regs: RTL and testbench
=============================

Name: timer_regs

Overview:
- Memory-mapped register front end for the timer block; the software-facing writer/reader of the timer control interface.
- Decodes simple CPU bus transactions into timer controls: ro_trig_start, ro_trig_halt, ro_mode, ro_termcount.
- Captures timer feedback (rf_status, rf_currcount, rf_int) into readable registers.
- Owns the sticky interrupt-pending bit and the irq line to the interrupt controller.

Parameters:
- TERM_RESET, 32'hFFFF_FFFF, reset value of the TERMCOUNT register / ro_termcount.

Ports:
- clk  input  1  master clock
- reset  input  1  asynchronous, active-low reset
- bus_req  input  1  transaction request; held until bus_ack
- bus_we  input  1  1 = write, 0 = read; sampled with bus_req
- bus_addr  input  5  byte address; bits [4:2] select the word, bits [1:0] ignored
- bus_wdata  input  32  write data
- bus_rdata  output  32  read data; valid only while bus_ack=1
- bus_ack  output  1  one-cycle completion pulse
- bus_err  output  1  unmapped-address flag; valid with bus_ack
- ro_trig_start  output  1  one-cycle start pulse to the timer
- ro_trig_halt  output  1  one-cycle halt pulse to the timer
- ro_mode  output  1  1 = continuous, 0 = one-shot
- ro_termcount  output  32  terminal count
- rf_status  input  1  timer running flag
- rf_currcount  input  32  timer current count
- rf_int  input  1  timer interrupt pulse/level
- irq  output  1  interrupt request, level

Behaviour:
- Reset (reset=0, asynchronous):
  - bus_ack=0, bus_err=0, bus_rdata=0.
  - ro_trig_start=0, ro_trig_halt=0, ro_mode=0, ro_termcount=TERM_RESET.
  - int_en=0, pending=0, irq=0, FSM=IDLE, rf_int edge-detect register=0.
- Register map (word index = bus_addr[4:2]):
  - 0 CTRL: bit0 mode RW; bit1 int_en RW; bit8 START write-1-pulse, reads 0; bit9 HALT write-1-pulse, reads 0. Other bits read 0.
  - 1 TERMCOUNT: RW, 32 bits.
  - 2 STATUS: bit0 = rf_status (RO, live); bit1 = pending (write 1 to clear). Other bits read 0.
  - 3 CURRCOUNT: RO = rf_currcount sampled at the accept edge. Writes ignored.
  - 4-7: unmapped. Reads return 0, writes have no effect, bus_err=1 with bus_ack.
- Handshake FSM:
  - States IDLE and ACK.
  - IDLE: bus_req=1 → accept on this edge (perform write / capture read data), go to ACK.
  - ACK: bus_ack=1 for exactly one cycle, then return to IDLE unconditionally.
  - If bus_req is still high in IDLE after ACK, it is a new transaction (back-to-back throughput = 1 per 2 cycles).
  - Read latency: 1 cycle from accept edge. bus_rdata returns to 0 when bus_ack=0.
- Triggers:
  - A CTRL write with bit8=1 drives ro_trig_start=1 for exactly the ACK cycle. Same rule for bit9 and ro_trig_halt.
  - Both bits set in one write: only ro_trig_halt pulses; ro_trig_start stays 0.
  - mode and int_en from the same write take effect on the ACK cycle, i.e. together with the pulse.
- Interrupt:
  - pending sets on a rising edge of rf_int (registered edge detect, 1-cycle delay).
  - Set and W1C in the same cycle: set wins, pending stays 1.
  - irq = pending & int_en, registered.
  - Clearing int_en masks irq but keeps pending.
- Reset mid-transaction: FSM returns to IDLE, no ack is issued, the partial write is discarded.

Optional Feature:
- Macro: TIMER_REGS_TC_DETECT_EN.
- Defined: pending additionally sets on the first cycle where rf_status=1 and rf_currcount==ro_termcount. This is a rising-edge compare, so one set per match episode. This covers timer builds whose rf_int is not driven.
- Not defined: pending sets only from rf_int rising edges. The comparator logic is absent.

Test Plan:
- Reset, then read addr 0x04 → rdata=32'hFFFF_FFFF, bus_err=0. Read 0x00 → 0. Read 0x08 → 0.
- Write 0x04=32'd10, then 0x00=32'h0000_0101 → ro_termcount=10, ro_mode=1, ro_trig_start=1 for exactly one cycle aligned to bus_ack. A subsequent read of 0x00 → 32'h0000_0001.
- Write 0x00=32'h0000_0300 → ro_trig_halt pulses one cycle, ro_trig_start stays 0 throughout.
- int_en=1, pulse rf_int → pending=1 and irq=1 within 2 cycles. Write 0x08=32'h2 in the same cycle as another rf_int edge → pending remains 1. A later W1C with no event → irq=0.
- Read 0x14 → bus_ack=1, bus_err=1, rdata=0. Write 0x1C → no register changes. Drop reset during the ACK of a TERMCOUNT write → ro_termcount=TERM_RESET, bus_ack=0.
- With TIMER_REGS_TC_DETECT_EN defined: rf_status=1, ro_termcount=5, drive rf_currcount 4→5→5 with rf_int=0 → pending sets once, and irq=1 if int_en=1. Without the macro → pending stays 0.

Source files
------------

// File: rtl/timer_regs_if.sv
// ----------------------------------------------------------------------------
// timer_regs_if -- simple CPU register bus used by the timer register block.
//
// Signals:
//   bus_req    request, held by the master until bus_ack
//   bus_we     1 = write, 0 = read (sampled with bus_req)
//   bus_addr   byte address; [4:2] selects the word, [1:0] ignored
//   bus_wdata  write data
//   bus_rdata  read data, valid only while bus_ack = 1
//   bus_ack    one-cycle completion pulse
//   bus_err    unmapped-address flag, valid with bus_ack
//
// Modports: master (CPU side), slave (register block side).
// ----------------------------------------------------------------------------
interface timer_regs_if;
    logic        bus_req;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/timer_regs.sv
// ----------------------------------------------------------------------------
// timer_regs -- memory-mapped register front end for the timer block.
//
// Ports:
//   clk            master clock
//   reset          asynchronous, active-low reset
//   bus            timer_regs_if.slave register bus
//   ro_trig_start  one-cycle start pulse to the timer (aligned with bus_ack)
//   ro_trig_halt   one-cycle halt pulse to the timer (aligned with bus_ack)
//   ro_mode        1 = continuous, 0 = one-shot
//   ro_termcount   terminal count
//   rf_status      timer running flag
//   rf_currcount   timer current count
//   rf_int         timer interrupt pulse/level
//   irq            registered interrupt request (pending & int_en)
//
// Register map (word = bus_addr[4:2]):
//   0 CTRL      bit0 mode, bit1 int_en, bit8 START (W1 pulse), bit9 HALT (W1 pulse)
//   1 TERMCOUNT RW
//   2 STATUS    bit0 rf_status (live), bit1 pending (W1C)
//   3 CURRCOUNT rf_currcount sampled at the accept edge, RO
//   4-7         unmapped: read 0, writes dropped, bus_err = 1
//
// Build option: define TIMER_REGS_TC_DETECT_EN to also set pending on the
// first cycle the running timer's count equals ro_termcount.
// ----------------------------------------------------------------------------
module timer_regs #(
    parameter logic [31:0] TERM_RESET = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         reset,
    timer_regs_if.slave  bus,
    output logic         ro_trig_start,
    output logic         ro_trig_halt,
    output logic         ro_mode,
    output logic [31:0]  ro_termcount,
    input  logic         rf_status,
    input  logic [31:0]  rf_currcount,
    input  logic         rf_int,
    output logic         irq
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        ack;
    logic [2:0]  word;
    logic        wr_ctrl, wr_term, wr_stat;
    logic [31:0] rd_mux;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        int_en;
    logic        pending;
    logic        rf_int_q;
    logic        pend_set, pend_clr;
    logic        unused_addr_lsb;

    assign word            = bus.bus_addr[4:2];
    assign unused_addr_lsb = ^bus.bus_addr[1:0];

    // Handshake FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ack     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.bus_req) begin
                    accept  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.bus_ack   = ack;
    assign bus.bus_rdata = rdata_q;
    assign bus.bus_err   = err_q;

    // Write decode
    assign wr_ctrl = accept && bus.bus_we && (word == 3'd0);
    assign wr_term = accept && bus.bus_we && (word == 3'd1);
    assign wr_stat = accept && bus.bus_we && (word == 3'd2);

    // Read mux, captured at the accept edge
    always_comb begin
        rd_mux = '0;
        case (word)
            3'd0:    rd_mux[1:0] = {int_en, ro_mode};
            3'd1:    rd_mux      = ro_termcount;
            3'd2:    rd_mux[1:0] = {pending, rf_status};
            3'd3:    rd_mux      = rf_currcount;
            default: rd_mux      = '0;
        endcase
    end

    // Interrupt pending sources; a set in the same cycle as W1C wins
`ifdef TIMER_REGS_TC_DETECT_EN
    logic tc_hit, tc_q;
    assign tc_hit = rf_status && (rf_currcount == ro_termcount);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tc_q <= 1'b0;
        else        tc_q <= tc_hit;
    end

    assign pend_set = (rf_int && !rf_int_q) || (tc_hit && !tc_q);
`else
    assign pend_set = rf_int && !rf_int_q;
`endif

    assign pend_clr = wr_stat && bus.bus_wdata[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q       <= '0;
            err_q         <= 1'b0;
            ro_trig_start <= 1'b0;
            ro_trig_halt  <= 1'b0;
            ro_mode       <= 1'b0;
            ro_termcount  <= TERM_RESET;
            int_en        <= 1'b0;
            pending       <= 1'b0;
            rf_int_q      <= 1'b0;
            irq           <= 1'b0;
        end else begin
            // rdata/err/pulses are loaded only on the accept edge, so they
            // are non-zero exactly during the ACK cycle
            rdata_q       <= (accept && !bus.bus_we) ? rd_mux : '0;
            err_q         <= accept && word[2];
            ro_trig_start <= wr_ctrl && bus.bus_wdata[8] && !bus.bus_wdata[9];
            ro_trig_halt  <= wr_ctrl && bus.bus_wdata[9];
            if (wr_ctrl) begin
                ro_mode <= bus.bus_wdata[0];
                int_en  <= bus.bus_wdata[1];
            end
            if (wr_term) ro_termcount <= bus.bus_wdata;
            rf_int_q      <= rf_int;
            pending       <= pend_set || (pending && !pend_clr);
            irq           <= pending && int_en;
        end
    end

endmodule

// File: tb/tb_timer_regs.sv
// ----------------------------------------------------------------------------
// tb_timer_regs -- self-checking bench for timer_regs: directed register-map,
// trigger, interrupt and reset cases followed by randomized bus traffic,
// all compared against a register-level reference model.
// ----------------------------------------------------------------------------
module tb_timer_regs;

    logic        clk;
    logic        reset;
    logic        ro_trig_start, ro_trig_halt, ro_mode;
    logic [31:0] ro_termcount;
    logic        rf_status;
    logic [31:0] rf_currcount;
    logic        rf_int;
    logic        irq;

    timer_regs_if bus_if ();

    timer_regs #(.TERM_RESET(32'hFFFF_FFFF)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .ro_trig_start (ro_trig_start),
        .ro_trig_halt  (ro_trig_halt),
        .ro_mode       (ro_mode),
        .ro_termcount  (ro_termcount),
        .rf_status     (rf_status),
        .rf_currcount  (rf_currcount),
        .rf_int        (rf_int),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic        m_mode;
    logic        m_int_en;
    logic [31:0] m_term;
    logic        m_pend;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 1'b0;
        m_int_en = 1'b0;
        m_term   = 32'hFFFF_FFFF;
        m_pend   = 1'b0;
    endtask

    // Pulses must only ever appear together with bus_ack
    always @(negedge clk) begin
        if (reset)
            check("trig_outside_ack",
                  {30'b0, ro_trig_start & ~bus_if.bus_ack, ro_trig_halt & ~bus_if.bus_ack},
                  32'h0);
    end

    // One bus transaction. Called just after a rising edge with the DUT idle.
    // int_pulse raises rf_int so its edge coincides with the accept edge.
    task automatic xfer(input logic we, input logic [4:0] addr,
                        input logic [31:0] wdata, input logic int_pulse);
        logic [2:0]  w;
        logic [31:0] exp_rd;
        logic        exp_err, exp_start, exp_halt;
        w         = addr[4:2];
        exp_err   = (w >= 3'd4);
        exp_start = 1'b0;
        exp_halt  = 1'b0;
        case (w)
            3'd0:    exp_rd = {30'b0, m_int_en, m_mode};
            3'd1:    exp_rd = m_term;
            3'd2:    exp_rd = {30'b0, m_pend, rf_status};
            3'd3:    exp_rd = rf_currcount;
            default: exp_rd = 32'h0;
        endcase
        if (we) begin
            if (w == 3'd0) begin
                m_mode    = wdata[0];
                m_int_en  = wdata[1];
                exp_halt  = wdata[9];
                exp_start = wdata[8] && !wdata[9];
            end else if (w == 3'd1) begin
                m_term = wdata;
            end else if (w == 3'd2 && wdata[1]) begin
                m_pend = 1'b0;
            end
        end
        if (int_pulse) m_pend = 1'b1;

        bus_if.bus_req   = 1'b1;
        bus_if.bus_we    = we;
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
        rf_int           = int_pulse;
        @(posedge clk); #1;
        bus_if.bus_req = 1'b0;
        rf_int         = 1'b0;
        check("ack", {31'b0, bus_if.bus_ack}, 32'h1);
        check("err", {31'b0, bus_if.bus_err}, {31'b0, exp_err});
        if (!we) check("rdata", bus_if.bus_rdata, exp_rd);
        check("trig_start", {31'b0, ro_trig_start}, {31'b0, exp_start});
        check("trig_halt", {31'b0, ro_trig_halt}, {31'b0, exp_halt});
        check("mode", {31'b0, ro_mode}, {31'b0, m_mode});
        check("termcount", ro_termcount, m_term);
        @(posedge clk); #1;
        check("ack_drop", {31'b0, bus_if.bus_ack}, 32'h0);
        check("rdata_idle", bus_if.bus_rdata, 32'h0);
        check("pulses_idle", {30'b0, ro_trig_start, ro_trig_halt}, 32'h0);
        check("irq", {31'b0, irq}, {31'b0, m_pend & m_int_en});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] wd, cc;
        logic [4:0]  ad;
        logic        we;

        reset            = 1'b0;
        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_addr  = '0;
        bus_if.bus_wdata = '0;
        rf_status        = 1'b0;
        rf_currcount     = '0;
        rf_int           = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, bus_if.bus_ack}, 32'h0);
        check("rst_err", {31'b0, bus_if.bus_err}, 32'h0);
        check("rst_rdata", bus_if.bus_rdata, 32'h0);
        check("rst_outs", {28'b0, ro_trig_start, ro_trig_halt, ro_mode, irq}, 32'h0);
        check("rst_term", ro_termcount, 32'hFFFF_FFFF);
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset values through the bus
        xfer(1'b0, 5'h04, 32'h0, 1'b0);
        xfer(1'b0, 5'h00, 32'h0, 1'b0);
        xfer(1'b0, 5'h08, 32'h0, 1'b0);

        // Termcount, mode + start, halt priority
        xfer(1'b1, 5'h04, 32'd10, 1'b0);
        xfer(1'b1, 5'h00, 32'h0000_0101, 1'b0);
        xfer(1'b0, 5'h00, 32'h0, 1'b0);
        xfer(1'b1, 5'h00, 32'h0000_0300, 1'b0);

        // Interrupt: enable, pulse rf_int
        xfer(1'b1, 5'h00, 32'h0000_0002, 1'b0);
        rf_int = 1'b1;
        @(posedge clk); #1;
        rf_int = 1'b0;
        m_pend = 1'b1;
        @(posedge clk); #1;
        check("irq_after_int", {31'b0, irq}, 32'h1);
        xfer(1'b0, 5'h08, 32'h0, 1'b0);
        // W1C colliding with a new rf_int edge: set wins
        xfer(1'b1, 5'h08, 32'h2, 1'b1);
        xfer(1'b0, 5'h08, 32'h0, 1'b0);
        // Plain W1C clears
        xfer(1'b1, 5'h08, 32'h2, 1'b0);
        xfer(1'b0, 5'h08, 32'h0, 1'b0);
        // Masking keeps pending
        rf_int = 1'b1;
        @(posedge clk); #1;
        rf_int = 1'b0;
        m_pend = 1'b1;
        @(posedge clk); #1;
        xfer(1'b1, 5'h00, 32'h0, 1'b0);
        xfer(1'b0, 5'h08, 32'h0, 1'b0);
        xfer(1'b1, 5'h08, 32'h2, 1'b0);

        // Unmapped accesses
        xfer(1'b0, 5'h14, 32'h0, 1'b0);
        xfer(1'b1, 5'h1C, 32'hFFFF_FFFF, 1'b0);
        xfer(1'b0, 5'h00, 32'h0, 1'b0);
        xfer(1'b0, 5'h04, 32'h0, 1'b0);

        // Reset during the ACK of a TERMCOUNT write
        bus_if.bus_req   = 1'b1;
        bus_if.bus_we    = 1'b1;
        bus_if.bus_addr  = 5'h04;
        bus_if.bus_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus_if.bus_req = 1'b0;
        check("mid_ack", {31'b0, bus_if.bus_ack}, 32'h1);
        reset = 1'b0;
        model_reset();
        #1;
        check("mid_rst_ack", {31'b0, bus_if.bus_ack}, 32'h0);
        check("mid_rst_term", ro_termcount, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, 5'h04, 32'h0, 1'b0);

        // Terminal-count compare
        xfer(1'b1, 5'h04, 32'd5, 1'b0);
        xfer(1'b1, 5'h00, 32'h2, 1'b0);
        rf_currcount = 32'd4;
        rf_status    = 1'b1;
        @(posedge clk); #1;
        rf_currcount = 32'd5;
        @(posedge clk); #1;
`ifdef TIMER_REGS_TC_DETECT_EN
        m_pend = 1'b1;
`endif
        @(posedge clk); #1;
        check("tc_irq", {31'b0, irq}, {31'b0, m_pend & m_int_en});
        xfer(1'b0, 5'h08, 32'h0, 1'b0);
        xfer(1'b1, 5'h08, 32'h2, 1'b0);
        xfer(1'b0, 5'h08, 32'h0, 1'b0);
        rf_status    = 1'b0;
        rf_currcount = '0;
        @(posedge clk); #1;

        // Randomized traffic (no interrupt events; counts never hit termcount)
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            ad = 5'($urandom_range(0, 31));
            wd = $urandom;
            if ($urandom_range(0, 3) == 0) wd[9:8] = 2'($urandom_range(0, 3));
            cc = $urandom;
            for (int k = 0; k < 16; k++)
                if (cc == m_term || cc == wd) cc = $urandom;
            rf_currcount = cc;
            rf_status    = 1'($urandom_range(0, 1));
            xfer(we, ad, wd, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
